booth_seq_multiplier: RTL and testbench

//   Sequential radix-2 Booth multiplier, generalised to WIDTH-bit operands with a

---
 rtl/booth_seq_multiplier.sv | 182 ++++++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier
//
// Sequential radix-2 Booth multiplier with a start/busy/done handshake.
// Each clock in RUN performs one Booth recode step: an optional add or
// subtract, then a one-bit arithmetic right shift. An operation takes
// WIDTH+1 steps.
//
// Both operands are widened by one bit before the multiply. In signed mode
// the extra bit is a sign extension; in unsigned mode it is a zero
// extension. Because of this, one signed Booth datapath covers both modes.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts any running operation
//   start        request; sampled only in IDLE or DONE
//   signed_mode  1: two's complement operands, 0: unsigned (captured with m/r)
//   m            multiplicand, captured on an accepted start
//   r            multiplier, captured on an accepted start
//   busy         high while the step sequence runs
//   done         one-cycle pulse when product has just been written
//   product      2*WIDTH-bit result, held until the next completion

module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     r,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Extended operand width. One extra bit keeps -(-2^(W-1)) and the
    // unsigned value 2^W-1 representable as signed E-bit numbers.
    localparam int E  = WIDTH + 1;
    // Width of the Booth accumulator: E-bit high half, E-bit low half, and
    // one recode bit below the LSB.
    localparam int PW = 2 * E + 1;
    // The step counter must be able to hold the value E.
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PW-1:0]      p_reg, p_next;
    logic [PW-1:0]      a_reg, a_next;
    logic [PW-1:0]      s_reg, s_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    // ------------------------------------------------------------------
    // Operand extension and negation
    // ------------------------------------------------------------------
    logic [E-1:0] mx;
    logic [E-1:0] rx;
    logic [E-1:0] neg_mx;
    logic         ext_m;
    logic         ext_r;

    // The top bit is a copy of the sign bit in signed mode and zero otherwise.
    assign ext_m = signed_mode & m[WIDTH-1];
    assign ext_r = signed_mode & r[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
            assign mx[gi] = m[gi];
            assign rx[gi] = r[gi];
        end
    endgenerate

    assign mx[E-1] = ext_m;
    assign rx[E-1] = ext_r;

    // Two's complement negation in E bits. This cannot overflow, because
    // mx is never the most negative E-bit value.
    assign neg_mx = E'(0) - mx;

    // ------------------------------------------------------------------
    // Booth step: recode the two LSBs of P, add A or S, then shift
    // ------------------------------------------------------------------
    logic [PW-1:0] p_sum;
    logic [PW-1:0] p_shift;

    always_comb begin
        p_sum = p_reg;
        case (p_reg[1:0])
            2'b01:   p_sum = p_reg + a_reg;   // end of a run of ones: +M
            2'b10:   p_sum = p_reg + s_reg;   // start of a run of ones: -M
            default: p_sum = p_reg;           // inside a run: no add
        endcase
    end

    // Arithmetic right shift by one. Every bit takes the bit above it, and
    // the MSB repeats itself to preserve the sign.
    generate
        for (genvar gi = 0; gi < PW - 1; gi++) begin : g_shift
            assign p_shift[gi] = p_sum[gi + 1];
        end
    endgenerate

    assign p_shift[PW-1] = p_sum[PW-1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        p_next       = p_reg;
        a_next       = a_reg;
        s_next       = s_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            // DONE accepts a new start just like IDLE does. This lets a
            // held start run back to back at one result every WIDTH+2 cycles.
            IDLE, DONE: begin
                if (start) begin
                    a_next     = {mx, {(E + 1){1'b0}}};
                    s_next     = {neg_mx, {(E + 1){1'b0}}};
                    p_next     = {{E{1'b0}}, rx, 1'b0};
                    cnt_next   = CW'(E);
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end

            RUN: begin
                p_next   = p_shift;
                cnt_next = cnt_reg - CW'(1);
                // On the final step, take the result straight from the
                // shifted value. That way product changes only on the edge
                // that enters DONE.
                if (cnt_reg == CW'(1)) begin
                    product_next = p_shift[2*WIDTH:1];
                    state_next   = DONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            a_reg       <= '0;
            s_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            p_reg       <= p_next;
            a_reg       <= a_next;
            s_reg       <= s_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    // The outputs are decoded straight from the state register, so busy
    // and done can never be high together.
    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Testbench for booth_seq_multiplier.
// Two instances are used: WIDTH=8 for the directed cases and WIDTH=4 for
// the exhaustive sweep.
// The driver pushes each expected product into a scoreboard queue. It also
// pushes the cycle in which done should appear.
// A monitor branch pops an entry and compares it each time done is seen.

module tb_booth_seq_multiplier;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sm8;
    logic [7:0]  m8, r8;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic        start4, sm4;
    logic [3:0]  m4, r4;
    logic        busy4, done4;
    logic [7:0]  prod4;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   bc8 = 0;
    int   bc4 = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .m(m8), .r(r8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .m(m4), .r(r4), .busy(busy4), .done(done4), .product(prod4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] ex);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; m8 = a; r8 = b;
        @(posedge clk); #1;
        e.prod = ex; e.cyc = cyc + 9;
        q8.push_back(e);
        start8 = 1'b0;
        $display("issue8 sm=%0d m=%02h r=%02h expect=%04h", sm, a, b, ex);
    endtask

    task automatic issue4(input logic sm, input logic [3:0] a, input logic [3:0] b, input logic [7:0] ex);
        exp_t e;
        @(negedge clk);
        start4 = 1'b1; sm4 = sm; m4 = a; r4 = b;
        @(posedge clk); #1;
        e.prod = {8'h00, ex}; e.cyc = cyc + 5;
        q4.push_back(e);
        start4 = 1'b0;
    endtask

    task automatic wait8();
        int k = 0;
        while (q8.size() != 0 && k < 40) begin @(negedge clk); k++; end
        if (q8.size() != 0) begin
            n_total++;
            $display("FAIL wait8 timeout: %0d results still outstanding", q8.size());
            q8.delete();
        end
    endtask

    task automatic wait4();
        int k = 0;
        while (q4.size() != 0 && k < 30) begin @(negedge clk); k++; end
        if (q4.size() != 0) begin
            n_total++;
            $display("FAIL wait4 timeout: %0d results still outstanding", q4.size());
            q4.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   c0;
        int   sa, sb;
        logic [7:0] ex4;

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; r8 = '0;
        start4 = 1'b0; sm4 = 1'b0; m4 = '0; r4 = '0;

        fork
            forever begin
                @(posedge clk); #1;
                if (rst) begin
                    bc8 = 0; bc4 = 0;
                end else begin
                    if (done8) begin
                        if (q8.size() == 0) begin
                            n_total++;
                            $display("FAIL done8 spurious: pulse at cycle %0d with nothing outstanding", cyc);
                        end else begin
                            e = q8.pop_front();
                            $display("done8 cycle=%0d product=%04h expect=%04h", cyc, prod8, e.prod);
                            check("prod8", 32'(prod8), 32'(e.prod));
                            check("done8 cycle", 32'(cyc), 32'(e.cyc));
                            check("busy8 run length", 32'(bc8), 32'd9);
                            check("busy8 with done", 32'(busy8), 32'd0);
                        end
                        bc8 = 0;
                    end else if (busy8) bc8++;
                    else bc8 = 0;

                    if (done4) begin
                        if (q4.size() == 0) begin
                            n_total++;
                            $display("FAIL done4 spurious: pulse at cycle %0d with nothing outstanding", cyc);
                        end else begin
                            e = q4.pop_front();
                            check("prod4", 32'(prod4), 32'(e.prod));
                            check("done4 cycle", 32'(cyc), 32'(e.cyc));
                            check("busy4 run length", 32'(bc4), 32'd5);
                        end
                        bc4 = 0;
                    end else if (busy4) bc4++;
                    else bc4 = 0;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset done8", 32'(done8), 32'd0);
        check("reset prod8", 32'(prod8), 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);
        check("reset prod4", 32'(prod4), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed WIDTH=8 vectors
        issue8(1'b1, 8'h80, 8'h80, 16'h4000); wait8();   // -128 * -128
        issue8(1'b1, 8'h7F, 8'hFF, 16'hFF81); wait8();   // 127 * -1
        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01); wait8();   // 255 * 255
        issue8(1'b0, 8'h80, 8'h02, 16'h0100); wait8();   // 128 * 2
        issue8(1'b1, 8'h00, 8'hA5, 16'h0000); wait8();   // zero
        issue8(1'b0, 8'h00, 8'hA5, 16'h0000); wait8();
        issue8(1'b1, 8'h01, 8'hFF, 16'hFFFF); wait8();   // 1 * -1
        issue8(1'b0, 8'h01, 8'hFF, 16'h00FF); wait8();   // 1 * 255
        issue8(1'b1, 8'h80, 8'h7F, 16'hC080); wait8();   // -128 * 127

        // Start held high: results back to back. The operands are changed
        // while an operation is in RUN; the running operation must not see it.
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; m8 = 8'd3; r8 = 8'd5;
        @(posedge clk); #1;
        c0 = cyc;
        e.prod = 16'h000F; e.cyc = c0 + 9; q8.push_back(e);
        m8 = 8'hF9; r8 = 8'd6;                           // -7 * 6 = -42
        repeat (10) @(posedge clk);
        #1;
        e.prod = 16'hFFD6; e.cyc = c0 + 19; q8.push_back(e);
        sm8 = 1'b0; m8 = 8'd200; r8 = 8'd3;              // 600
        repeat (4) @(posedge clk);
        #1;
        check("product held during run", 32'(prod8), 32'h000F);
        repeat (6) @(posedge clk);
        #1;
        e.prod = 16'h0258; e.cyc = c0 + 29; q8.push_back(e);
        start8 = 1'b0;
        wait8();

        // A start pulse during RUN is ignored
        issue8(1'b0, 8'd100, 8'd2, 16'd200);
        repeat (3) @(negedge clk);
        start8 = 1'b1; m8 = 8'd7; r8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        check("product held before done", 32'(prod8), 32'h0258);
        wait8();

        // Reset in the 4th RUN cycle
        issue8(1'b1, 8'hFB, 8'd9, 16'hFFD3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q8.delete();
        @(posedge clk); #1;
        check("abort busy8", 32'(busy8), 32'd0);
        check("abort done8", 32'(done8), 32'd0);
        check("abort prod8", 32'(prod8), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (12) @(negedge clk);                      // a done pulse here is reported spurious
        issue8(1'b1, 8'hFB, 8'd9, 16'hFFD3); wait8();    // -5 * 9 = -45

        // WIDTH=4: all operand pairs, both modes
        issue4(1'b1, 4'h8, 4'h7, 8'hC8); wait4();        // -8 * 7 = -56
        for (int md = 0; md < 2; md++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    if (md == 1) begin
                        sa = (a > 7) ? a - 16 : a;
                        sb = (b > 7) ? b - 16 : b;
                    end else begin
                        sa = a;
                        sb = b;
                    end
                    ex4 = 8'((sa * sb) & 255);
                    issue4(md[0], 4'(a), 4'(b), ex4);
                    wait4();
                end
            end
        end
        $display("width4 sweep complete: 512 operations issued");

        repeat (15) @(negedge clk);
        check("q8 drained", 32'(q8.size()), 32'd0);
        check("q4 drained", 32'(q4.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
